// File: rtl/axi_read_slave_mem.sv
// AXI4 read-only slave backed by a 256-bit wide word memory.
// Two-entry AR queue, FIXED/INCR/WRAP bursts, SLVERR/DECERR reporting.
module axi_read_slave_mem #(
    parameter int MEM_AW   = 6,
    parameter bit ERR_ZERO = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [MEM_AW-1:0] i_wr_addr,
    input  logic [255:0]      i_wr_data,
    input  logic [6:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [6:0]        rid,
    output logic [255:0]      rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready
);

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    typedef struct packed {
        logic [6:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BURST
    } state_t;

    logic [255:0] mem [2**MEM_AW];

    ar_t        fifo_q [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic [1:0] count_nxt;
    logic       push;
    logic       pop;
    ar_t        head;

    state_t      state;
    logic [6:0]  cur_id;
    logic [31:0] cur_addr;
    logic [7:0]  cur_len;
    logic [2:0]  cur_size;
    logic [1:0]  cur_burst;
    logic        cur_slverr;
    logic [7:0]  beat_cnt;

    logic [31:0] sz_bytes;
    logic [31:0] aligned;
    logic [31:0] incr_addr;
    logic [31:0] wrap_mask;
    logic [31:0] nxt_addr;
    logic [31:0] beat_addr;
    logic        beat_dec;
    logic [1:0]  beat_resp;
    logic [255:0] beat_data;
    logic        head_slverr;

    // Queue control: a push needs a free slot, a pop happens when the engine is idle.
    always_comb begin
        push      = arvalid && arready;
        pop       = (state == IDLE) && (count != 2'd0);
        head      = fifo_q[rd_ptr];
        count_nxt = count + {1'b0, push} - {1'b0, pop};
    end

    // Burst legality of the request at the head of the queue.
    always_comb begin
        head_slverr = 1'b0;
        if (head.size > 3'd5)
            head_slverr = 1'b1;
        if (head.burst == 2'd3)
            head_slverr = 1'b1;
        if (head.burst == BURST_WRAP &&
            !(head.len == 8'd1 || head.len == 8'd3 ||
              head.len == 8'd7 || head.len == 8'd15))
            head_slverr = 1'b1;
    end

    // Next-beat address and the response/data that beat will carry.
    always_comb begin
        sz_bytes  = 32'd1 << cur_size;
        aligned   = cur_addr & ~(sz_bytes - 32'd1);
        incr_addr = aligned + sz_bytes;
        wrap_mask = (({24'd0, cur_len} + 32'd1) << cur_size) - 32'd1;
        unique case (cur_burst)
            BURST_FIXED: nxt_addr = cur_addr;
            BURST_WRAP:  nxt_addr = (cur_addr & ~wrap_mask) |
                                    (incr_addr & wrap_mask);
            default:     nxt_addr = incr_addr;
        endcase
        beat_addr = (state == LOAD) ? cur_addr : nxt_addr;
        beat_dec  = |beat_addr[31:MEM_AW+5];
        if (cur_slverr)
            beat_resp = RESP_SLVERR;
        else if (beat_dec)
            beat_resp = RESP_DECERR;
        else
            beat_resp = RESP_OKAY;
        if (ERR_ZERO && beat_resp != RESP_OKAY)
            beat_data = '0;
        else
            beat_data = mem[beat_addr[MEM_AW+4:5]];
    end

    // Backdoor preload port; the memory itself is never reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en)
            mem[i_wr_addr] <= i_wr_data;
    end

    // Two-entry AR queue with a registered not-full ready.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            arready <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= '{id: arid, addr: araddr, len: arlen,
                                    size: arsize, burst: arburst};
                wr_ptr <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count   <= count_nxt;
            arready <= (count_nxt != 2'd2);
        end
    end

    // Read engine: take a request, read its first word, then stream beats.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            rvalid     <= 1'b0;
            rlast      <= 1'b0;
            rresp      <= 2'd0;
            rid        <= 7'd0;
            rdata      <= '0;
            cur_id     <= 7'd0;
            cur_addr   <= 32'd0;
            cur_len    <= 8'd0;
            cur_size   <= 3'd0;
            cur_burst  <= 2'd0;
            cur_slverr <= 1'b0;
            beat_cnt   <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        cur_id     <= head.id;
                        cur_addr   <= head.addr;
                        cur_len    <= head.len;
                        cur_size   <= head.size;
                        cur_burst  <= head.burst;
                        cur_slverr <= head_slverr;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    rvalid   <= 1'b1;
                    rid      <= cur_id;
                    rdata    <= beat_data;
                    rresp    <= beat_resp;
                    rlast    <= (cur_len == 8'd0);
                    beat_cnt <= 8'd0;
                    cur_addr <= beat_addr;
                    state    <= BURST;
                end
                BURST: begin
                    if (rready) begin
                        if (rlast) begin
                            rvalid <= 1'b0;
                            rlast  <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            rdata    <= beat_data;
                            rresp    <= beat_resp;
                            rlast    <= (beat_cnt + 8'd1 == cur_len);
                            beat_cnt <= beat_cnt + 8'd1;
                            cur_addr <= beat_addr;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_slave_mem.sv
// Directed bench for axi_read_slave_mem: latency, burst types, errors,
// backpressure with queued requests, and mid-burst reset.
module tb_axi_read_slave_mem;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_wr_en;
    logic [5:0]   i_wr_addr;
    logic [255:0] i_wr_data;
    logic [6:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [6:0]   rid;
    logic [255:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    int n_cmp = 0;
    int n_bad = 0;

    axi_read_slave_mem #(.MEM_AW(6), .ERR_ZERO(1'b1)) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_wr_en  (i_wr_en),
        .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data),
        .arid     (arid),
        .araddr   (araddr),
        .arlen    (arlen),
        .arsize   (arsize),
        .arburst  (arburst),
        .arvalid  (arvalid),
        .arready  (arready),
        .rid      (rid),
        .rdata    (rdata),
        .rresp    (rresp),
        .rlast    (rlast),
        .rvalid   (rvalid),
        .rready   (rready)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [255:0] d);
        i_wr_en   = 1'b1;
        i_wr_addr = a;
        i_wr_data = d;
        step();
        i_wr_en   = 1'b0;
    endtask

    // Present one AR and return #1 after its handshake edge.
    task automatic ar(input logic [6:0] id, input logic [31:0] a,
                      input logic [7:0] len, input logic [2:0] sz,
                      input logic [1:0] bt);
        int n;
        arid    = id;
        araddr  = a;
        arlen   = len;
        arsize  = sz;
        arburst = bt;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin
            step();
            n++;
        end
        chk("ar_accept", {31'd0, arready}, 256'd1);
        step();
        arvalid = 1'b0;
    endtask

    // Check the currently presented beat, then consume it (rready=1).
    task automatic rd_beat(input string tag, input logic [6:0] id,
                           input logic [255:0] d, input logic [1:0] resp,
                           input logic last, input bit wait_ok);
        int n;
        n = 0;
        while (!rvalid && wait_ok && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, {255'd0, rvalid}, 256'd1);
        chk({tag, "_data"}, rdata, d);
        chk({tag, "_meta"}, {246'd0, rid, rresp, rlast},
            {246'd0, id, resp, last});
        step();
    endtask

    logic [255:0] exp_d  [6];
    logic [6:0]   exp_id [6];
    logic         exp_l  [6];

    initial begin
        int idx;
        int n;
        bit stall;
        logic [265:0] saved;

        i_reset   = 1'b1;
        i_wr_en   = 1'b0;
        i_wr_addr = '0;
        i_wr_data = '0;
        arid      = '0;
        araddr    = '0;
        arlen     = '0;
        arsize    = '0;
        arburst   = '0;
        arvalid   = 1'b0;
        rready    = 1'b1;

        wr(6'd0, 256'hA0);
        wr(6'd1, 256'hA1);
        wr(6'd2, 256'hA2);
        wr(6'd3, 256'hA3);
        wr(6'd63, 256'hBF);

        chk("rst_arready", {255'd0, arready}, 256'd0);
        chk("rst_rvalid", {255'd0, rvalid}, 256'd0);
        chk("rst_rmeta", {246'd0, rid, rresp, rlast}, 256'd0);
        chk("rst_rdata", rdata, 256'd0);

        i_reset = 1'b0;
        step();
        chk("rel_arready", {255'd0, arready}, 256'd1);

        // INCR 4 beats, latency k+2, no bubbles
        ar(7'h12, 32'h0, 8'd3, 3'd5, 2'd1);
        chk("lat_k0", {255'd0, rvalid}, 256'd0);
        step();
        chk("lat_k1", {255'd0, rvalid}, 256'd0);
        step();
        rd_beat("incr0", 7'h12, 256'hA0, 2'd0, 1'b0, 1'b0);
        rd_beat("incr1", 7'h12, 256'hA1, 2'd0, 1'b0, 1'b0);
        rd_beat("incr2", 7'h12, 256'hA2, 2'd0, 1'b0, 1'b0);
        rd_beat("incr3", 7'h12, 256'hA3, 2'd0, 1'b1, 1'b0);
        chk("incr_end", {255'd0, rvalid}, 256'd0);

        // WRAP 4 beats from 0x40 -> words 2,3,0,1
        ar(7'h05, 32'h40, 8'd3, 3'd5, 2'd2);
        rd_beat("wrap0", 7'h05, 256'hA2, 2'd0, 1'b0, 1'b1);
        rd_beat("wrap1", 7'h05, 256'hA3, 2'd0, 1'b0, 1'b0);
        rd_beat("wrap2", 7'h05, 256'hA0, 2'd0, 1'b0, 1'b0);
        rd_beat("wrap3", 7'h05, 256'hA1, 2'd0, 1'b1, 1'b0);

        // FIXED repeats the same word
        ar(7'h06, 32'h20, 8'd2, 3'd5, 2'd0);
        rd_beat("fix0", 7'h06, 256'hA1, 2'd0, 1'b0, 1'b1);
        rd_beat("fix1", 7'h06, 256'hA1, 2'd0, 1'b0, 1'b0);
        rd_beat("fix2", 7'h06, 256'hA1, 2'd0, 1'b1, 1'b0);

        // INCR running off the top of memory
        ar(7'h07, 32'h7E0, 8'd1, 3'd5, 2'd1);
        rd_beat("top0", 7'h07, 256'hBF, 2'd0, 1'b0, 1'b1);
        rd_beat("top1", 7'h07, 256'h0, 2'd3, 1'b1, 1'b0);

        // oversize beats -> SLVERR on all
        ar(7'h08, 32'h0, 8'd2, 3'd6, 2'd1);
        rd_beat("big0", 7'h08, 256'h0, 2'd2, 1'b0, 1'b1);
        rd_beat("big1", 7'h08, 256'h0, 2'd2, 1'b0, 1'b0);
        rd_beat("big2", 7'h08, 256'h0, 2'd2, 1'b1, 1'b0);

        // WRAP with illegal length -> SLVERR on all
        ar(7'h09, 32'h0, 8'd2, 3'd5, 2'd2);
        rd_beat("bwrap0", 7'h09, 256'h0, 2'd2, 1'b0, 1'b1);
        rd_beat("bwrap1", 7'h09, 256'h0, 2'd2, 1'b0, 1'b0);
        rd_beat("bwrap2", 7'h09, 256'h0, 2'd2, 1'b1, 1'b0);

        // three queued requests under backpressure
        rready = 1'b0;
        ar(7'h01, 32'h00, 8'd1, 3'd5, 2'd1);
        ar(7'h02, 32'h20, 8'd1, 3'd5, 2'd1);
        ar(7'h03, 32'h40, 8'd1, 3'd5, 2'd1);
        chk("q_full", {255'd0, arready}, 256'd0);
        exp_d  = '{256'hA0, 256'hA1, 256'hA1, 256'hA2, 256'hA2, 256'hA3};
        exp_id = '{7'h01, 7'h01, 7'h02, 7'h02, 7'h03, 7'h03};
        exp_l  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        idx   = 0;
        n     = 0;
        stall = 1'b0;
        saved = '0;
        while (idx < 6 && n < 300) begin
            if (stall) begin
                chk("stall_hold", {246'd0, rid, rresp, rlast},
                    {246'd0, saved[265:256]});
                chk("stall_data", rdata, saved[255:0]);
            end
            rready = 1'($urandom_range(0, 1));
            if (rvalid && rready) begin
                chk("q_data", rdata, exp_d[idx]);
                chk("q_meta", {246'd0, rid, rresp, rlast},
                    {246'd0, exp_id[idx], 2'd0, exp_l[idx]});
                idx++;
            end
            stall = rvalid && !rready;
            saved = {rid, rresp, rlast, rdata};
            step();
            n++;
        end
        chk("q_done", 256'(idx), 256'd6);
        rready = 1'b1;

        // reset in the middle of an 8-beat burst
        ar(7'h0A, 32'h0, 8'd7, 3'd5, 2'd1);
        rd_beat("rb0", 7'h0A, 256'hA0, 2'd0, 1'b0, 1'b1);
        rd_beat("rb1", 7'h0A, 256'hA1, 2'd0, 1'b0, 1'b0);
        chk("rb2_data", rdata, 256'hA2);
        i_reset = 1'b1;
        step();
        chk("rb_rvalid", {255'd0, rvalid}, 256'd0);
        chk("rb_arready", {255'd0, arready}, 256'd0);
        i_reset = 1'b0;
        step();
        chk("rb_rel_arready", {255'd0, arready}, 256'd1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (rvalid)
                n++;
            step();
        end
        chk("rb_no_stale", 256'(n), 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
